// File: rtl/aclk_pkg.sv
// -----------------------------------------------------------------------------
// aclk_pkg
// Shared types and constants for the alarm-clock time counter.
//   bcd_digit_t  : one 4-bit BCD digit
//   DIGIT_UNSET  : sentinel shown on every digit before a valid time is loaded
//   time_t       : HH:MM as four BCD digits
//   state_t      : counter FSM states
//   time_is_valid: range check applied to a requested load
// -----------------------------------------------------------------------------
package aclk_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t DIGIT_UNSET     = 4'hA;
   localparam bcd_digit_t DIGIT_MAX       = 4'd9;
   localparam bcd_digit_t MS_HR_MAX       = 4'd2;
   // With ms_hr at its maximum the hours only run 20..23.
   localparam bcd_digit_t LS_HR_MAX_AT_20 = 4'd3;
   localparam bcd_digit_t MS_MIN_MAX      = 4'd5;

   typedef struct packed {
      bcd_digit_t ms_hr;
      bcd_digit_t ls_hr;
      bcd_digit_t ms_min;
      bcd_digit_t ls_min;
   } time_t;

   typedef enum logic {
      ST_UNSET = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // True when t is a legal 24-hour BCD time (00:00 .. 23:59).
   function automatic logic time_is_valid(input time_t t);
      logic hr_ok;
      logic min_ok;
      hr_ok  = (t.ms_hr <= MS_HR_MAX) && (t.ls_hr <= DIGIT_MAX) &&
               !((t.ms_hr == MS_HR_MAX) && (t.ls_hr > LS_HR_MAX_AT_20));
      min_ok = (t.ms_min <= MS_MIN_MAX) && (t.ls_min <= DIGIT_MAX);
      return hr_ok && min_ok;
   endfunction

endpackage

// File: rtl/aclk_time_incr.sv
// -----------------------------------------------------------------------------
// aclk_time_incr
// Combinational "plus one minute" on a BCD HH:MM value, wrapping 23:59->00:00.
//   cur_time  : current time (assumed valid BCD)
//   next_time : cur_time advanced by one minute
// -----------------------------------------------------------------------------
module aclk_time_incr
   import aclk_pkg::*;
(
   input  time_t cur_time,
   output time_t next_time
);

   // Ripple the carry from ls_min up through the hour digits.
   always_comb begin
      next_time = cur_time;
      if (cur_time.ls_min != DIGIT_MAX) begin
         next_time.ls_min = cur_time.ls_min + 4'd1;
      end else begin
         next_time.ls_min = 4'd0;
         if (cur_time.ms_min != MS_MIN_MAX) begin
            next_time.ms_min = cur_time.ms_min + 4'd1;
         end else begin
            next_time.ms_min = 4'd0;
            if ((cur_time.ms_hr == MS_HR_MAX) && (cur_time.ls_hr == LS_HR_MAX_AT_20)) begin
               next_time.ms_hr = 4'd0;
               next_time.ls_hr = 4'd0;
            end else if (cur_time.ls_hr == DIGIT_MAX) begin
               next_time.ls_hr = 4'd0;
               next_time.ms_hr = cur_time.ms_hr + 4'd1;
            end else begin
               next_time.ls_hr = cur_time.ls_hr + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/aclk_counter.sv
// -----------------------------------------------------------------------------
// aclk_counter
// Alarm-clock time-of-day counter. Counts one_second strobes into minutes and
// keeps a BCD HH:MM time, loadable at any time with range checking.
//   clock, reset_n        : rising-edge clock, synchronous active-low reset
//   one_second            : one-cycle timebase strobe
//   fast_watch            : level, minute length FAST_FACTOR instead of SEC_PER_MIN
//   load_new_c            : one-cycle request to load new_time_* digits
//   new_time_*            : BCD time to load
//   current_time_*        : registered BCD time (4'hA on all digits until set)
//   one_minute            : registered pulse on each minute advance
//   time_valid            : high once a valid time has been loaded
//   load_err              : registered pulse when a load request is rejected
// -----------------------------------------------------------------------------
module aclk_counter
   import aclk_pkg::*;
#(
   parameter int SEC_PER_MIN = 60,
   parameter int FAST_FACTOR = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       one_second,
   input  logic       fast_watch,
   input  logic       load_new_c,
   input  logic [3:0] new_time_ms_hr,
   input  logic [3:0] new_time_ls_hr,
   input  logic [3:0] new_time_ms_min,
   input  logic [3:0] new_time_ls_min,
   output logic [3:0] current_time_ms_hr,
   output logic [3:0] current_time_ls_hr,
   output logic [3:0] current_time_ms_min,
   output logic [3:0] current_time_ls_min,
   output logic       one_minute,
   output logic       time_valid,
   output logic       load_err
);

   localparam int CNT_MAX = (SEC_PER_MIN > FAST_FACTOR) ? SEC_PER_MIN : FAST_FACTOR;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LIM_NORMAL = CNT_W'(SEC_PER_MIN - 1);
   localparam logic [CNT_W-1:0] LIM_FAST   = CNT_W'(FAST_FACTOR - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   time_t            time_r;
   time_t            time_nxt_s;
   time_t            time_incr_s;
   time_t            load_time_s;
   logic [CNT_W-1:0] sec_cnt_r;
   logic [CNT_W-1:0] sec_cnt_nxt_s;
   logic [CNT_W-1:0] sec_lim_s;
   logic             fast_watch_r;
   logic             one_minute_r;
   logic             one_minute_nxt_s;
   logic             load_err_r;
   logic             load_err_nxt_s;
   logic             time_valid_r;
   logic             load_ok_s;
   logic             fast_chg_s;
   logic             tick_s;

   assign load_time_s = '{ms_hr: new_time_ms_hr, ls_hr: new_time_ls_hr,
                          ms_min: new_time_ms_min, ls_min: new_time_ls_min};
   assign load_ok_s   = load_new_c && time_is_valid(load_time_s);
   assign fast_chg_s  = (fast_watch != fast_watch_r);
   assign sec_lim_s   = fast_watch ? LIM_FAST : LIM_NORMAL;
   // A valid load or a mode change swallows the strobe; a rejected load does not.
   assign tick_s      = one_second && (state_r == ST_RUN) && !load_ok_s && !fast_chg_s;

   aclk_time_incr u_time_incr (
      .cur_time  (time_r),
      .next_time (time_incr_s)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r <= ST_UNSET;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: only a valid load leaves UNSET; RUN is left only by reset.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_UNSET: begin
            if (load_ok_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_UNSET;
            end
         end
         ST_RUN: begin
            state_nxt_s = ST_RUN;
         end
         default: begin
            state_nxt_s = ST_UNSET;
         end
      endcase
   end

   // Output/datapath next values: load, then mode change, then seconds tick.
   always_comb begin
      time_nxt_s       = time_r;
      sec_cnt_nxt_s    = sec_cnt_r;
      one_minute_nxt_s = 1'b0;
      load_err_nxt_s   = 1'b0;
      if (load_ok_s) begin
         time_nxt_s    = load_time_s;
         sec_cnt_nxt_s = '0;
      end else begin
         load_err_nxt_s = load_new_c;
         if (fast_chg_s) begin
            sec_cnt_nxt_s = '0;
         end else if (tick_s) begin
            if (sec_cnt_r == sec_lim_s) begin
               sec_cnt_nxt_s    = '0;
               time_nxt_s       = time_incr_s;
               one_minute_nxt_s = 1'b1;
            end else begin
               sec_cnt_nxt_s = sec_cnt_r + CNT_W'(1'b1);
            end
         end else begin
            sec_cnt_nxt_s = sec_cnt_r;
         end
      end
   end

   // Datapath and output registers; fast_watch is tracked even in reset so a
   // level held through reset is not mistaken for a change afterwards.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         time_r       <= '{default: DIGIT_UNSET};
         sec_cnt_r    <= '0;
         fast_watch_r <= fast_watch;
         one_minute_r <= 1'b0;
         load_err_r   <= 1'b0;
         time_valid_r <= 1'b0;
      end else begin
         time_r       <= time_nxt_s;
         sec_cnt_r    <= sec_cnt_nxt_s;
         fast_watch_r <= fast_watch;
         one_minute_r <= one_minute_nxt_s;
         load_err_r   <= load_err_nxt_s;
         time_valid_r <= (state_nxt_s == ST_RUN);
      end
   end

   assign current_time_ms_hr  = time_r.ms_hr;
   assign current_time_ls_hr  = time_r.ls_hr;
   assign current_time_ms_min = time_r.ms_min;
   assign current_time_ls_min = time_r.ls_min;
   assign one_minute          = one_minute_r;
   assign load_err            = load_err_r;
   assign time_valid          = time_valid_r;

endmodule

// File: tb/tb_aclk_counter.sv
// -----------------------------------------------------------------------------
// tb_aclk_counter
// Scoreboard bench: each driven cycle pushes the model's expected outputs,
// which are popped and compared one edge later.
// -----------------------------------------------------------------------------
module tb_aclk_counter;

   localparam int SPM = 60;
   localparam int FF  = 1;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       one_second;
   logic       fast_watch;
   logic       load_new_c;
   logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;
   logic [3:0] current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min;
   logic       one_minute, time_valid, load_err;

   aclk_counter #(.SEC_PER_MIN(SPM), .FAST_FACTOR(FF)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .one_second          (one_second),
      .fast_watch          (fast_watch),
      .load_new_c          (load_new_c),
      .new_time_ms_hr      (new_time_ms_hr),
      .new_time_ls_hr      (new_time_ls_hr),
      .new_time_ms_min     (new_time_ms_min),
      .new_time_ls_min     (new_time_ls_min),
      .current_time_ms_hr  (current_time_ms_hr),
      .current_time_ls_hr  (current_time_ls_hr),
      .current_time_ms_min (current_time_ms_min),
      .current_time_ls_min (current_time_ls_min),
      .one_minute          (one_minute),
      .time_valid          (time_valid),
      .load_err            (load_err)
   );

   always #5 clock = ~clock;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int om_count  = 0;

   logic [18:0] exp_q[$];   // {time[15:0], one_minute, load_err, time_valid}

   // reference model state, in plain integers
   int m_hr = 0, m_mn = 0, m_cnt = 0;
   bit m_valid = 1'b0, m_fw_q = 1'b0;

   logic [15:0] obs_time;
   logic        obs_om, obs_le, obs_tv;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit model_load_ok(input logic [15:0] t);
      int mh, lh, mm, lm;
      mh = int'(t[15:12]); lh = int'(t[11:8]); mm = int'(t[7:4]); lm = int'(t[3:0]);
      return (mh <= 9) && (lh <= 9) && (mm <= 9) && (lm <= 9) &&
             (mh * 10 + lh <= 23) && (mm <= 5);
   endfunction

   // Drive one cycle, advance the model, then compare one edge later.
   task automatic step(input bit rst, input bit ld, input logic [15:0] t,
                       input bit tick, input bit fw, input string tag);
      bit om, le, fchg;
      int n;
      logic [15:0] et;
      logic [18:0] exp_v;
      logic [18:0] got_v;
      reset_n = ~rst; reset_n = !rst ? 1'b0 : 1'b1;
      load_new_c = ld; one_second = tick; fast_watch = fw;
      {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min} = t;
      om = 1'b0; le = 1'b0;
      if (!rst) begin
         m_valid = 1'b0; m_cnt = 0; m_fw_q = fw;
      end else begin
         fchg = (fw != m_fw_q);
         m_fw_q = fw;
         if (ld && model_load_ok(t)) begin
            m_hr = int'(t[15:12]) * 10 + int'(t[11:8]);
            m_mn = int'(t[7:4]) * 10 + int'(t[3:0]);
            m_cnt = 0; m_valid = 1'b1;
         end else begin
            le = ld;
            if (fchg) m_cnt = 0;
            else if (m_valid && tick) begin
               n = fw ? FF : SPM;
               m_cnt++;
               if (m_cnt == n) begin
                  m_cnt = 0; om = 1'b1; m_mn++;
                  if (m_mn == 60) begin m_mn = 0; m_hr = (m_hr + 1) % 24; end
               end
            end
         end
      end
      et = m_valid ? {4'(m_hr / 10), 4'(m_hr % 10), 4'(m_mn / 10), 4'(m_mn % 10)} : 16'hAAAA;
      exp_q.push_back({et, om, le, m_valid});
      @(posedge clock);
      #1;
      exp_v = exp_q.pop_front();
      obs_time = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};
      obs_om = one_minute; obs_le = load_err; obs_tv = time_valid;
      got_v = {obs_time, obs_om, obs_le, obs_tv};
      check_eq({tag, "_time"}, 32'(got_v[18:3]), 32'(exp_v[18:3]));
      check_eq({tag, "_om"},   32'(got_v[2]),    32'(exp_v[2]));
      check_eq({tag, "_le"},   32'(got_v[1]),    32'(exp_v[1]));
      check_eq({tag, "_tv"},   32'(got_v[0]),    32'(exp_v[0]));
      if (obs_om) om_count++;
   endtask

   task automatic ticks(input int n, input bit fw, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b1, fw, tag);
   endtask

   initial begin
      reset_n = 1'b0; one_second = 1'b0; fast_watch = 1'b0; load_new_c = 1'b0;
      {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min} = 16'h0000;

      // reset state
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "rst");
      step(1'b0, 1'b1, 16'h1200, 1'b1, 1'b0, "rst_prio");
      check_eq("rst_digits", 32'(obs_time), 32'h0000AAAA);
      check_eq("rst_tv", 32'(obs_tv), 32'd0);

      // ticks while unset are ignored
      om_count = 0;
      ticks(5, 1'b0, "unset_tick");
      check_eq("unset_digits", 32'(obs_time), 32'h0000AAAA);
      check_eq("unset_om_count", 32'(om_count), 32'd0);

      // rejected loads keep UNSET
      step(1'b1, 1'b1, 16'h2400, 1'b0, 1'b0, "bad24");
      check_eq("bad24_le", 32'(obs_le), 32'd1);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "le_clear");
      check_eq("le_one_cycle", 32'(obs_le), 32'd0);
      step(1'b1, 1'b1, 16'h127A, 1'b0, 1'b0, "bad7A");
      check_eq("bad7A_le", 32'(obs_le), 32'd1);
      check_eq("bad_digits", 32'(obs_time), 32'h0000AAAA);
      check_eq("bad_tv", 32'(obs_tv), 32'd0);

      // 23:59 wraps to 00:00 after 60 ticks
      step(1'b1, 1'b1, 16'h2359, 1'b0, 1'b0, "ld2359");
      om_count = 0;
      ticks(59, 1'b0, "run2359");
      check_eq("pre_wrap", 32'(obs_time), 32'h00002359);
      ticks(1, 1'b0, "wrap");
      check_eq("wrap_digits", 32'(obs_time), 32'h00000000);
      check_eq("wrap_om", 32'(obs_om), 32'd1);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "post_wrap");
      check_eq("wrap_om_count", 32'(om_count), 32'd1);

      // fast watch: one tick per minute, hour carry
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "fw_on");
      step(1'b1, 1'b1, 16'h0959, 1'b0, 1'b1, "ld0959");
      ticks(1, 1'b1, "fw1");
      check_eq("fw_1000", 32'(obs_time), 32'h00001000);
      ticks(1, 1'b1, "fw2");
      check_eq("fw_1001", 32'(obs_time), 32'h00001001);

      // load beats a coincident tick at counter 59
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "fw_off");
      step(1'b1, 1'b1, 16'h1229, 1'b0, 1'b0, "ld1229");
      ticks(59, 1'b0, "run1229");
      step(1'b1, 1'b1, 16'h1230, 1'b1, 1'b0, "ld_tick");
      check_eq("ld_tick_digits", 32'(obs_time), 32'h00001230);
      check_eq("ld_tick_om", 32'(obs_om), 32'd0);
      ticks(59, 1'b0, "run1230");
      check_eq("cnt_cleared", 32'(obs_time), 32'h00001230);
      ticks(1, 1'b0, "adv1231");
      check_eq("adv_1231", 32'(obs_time), 32'h00001231);

      // reset mid-minute with coincident load/tick
      step(1'b1, 1'b1, 16'h0815, 1'b0, 1'b0, "ld0815");
      ticks(30, 1'b0, "run0815");
      step(1'b0, 1'b1, 16'h0815, 1'b1, 1'b0, "mid_rst");
      check_eq("mid_rst_digits", 32'(obs_time), 32'h0000AAAA);
      check_eq("mid_rst_tv", 32'(obs_tv), 32'd0);
      step(1'b1, 1'b1, 16'h0815, 1'b0, 1'b0, "reld0815");
      check_eq("reld_tv", 32'(obs_tv), 32'd1);
      ticks(59, 1'b0, "rerun0815");
      check_eq("reld_hold", 32'(obs_time), 32'h00000815);
      ticks(1, 1'b0, "adv0816");
      check_eq("adv_0816", 32'(obs_time), 32'h00000816);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit r_rst, r_ld, r_tk, r_fw;
         logic [15:0] r_t;
         r_rst = ($urandom_range(0, 59) != 0);
         r_ld  = ($urandom_range(0, 11) == 0);
         r_tk  = ($urandom_range(0, 1) == 0);
         r_fw  = fast_watch ^ ($urandom_range(0, 39) == 0);
         r_t   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 10)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 10))};
         step(r_rst, r_ld, r_t, r_tk, r_fw, "rand");
      end

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
